// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg -- configurable UART transmitter with a one-entry holding register
//
// Frame format: one start bit (0), DATA_BITS data bits sent LSB first, an
// optional parity bit, then STOP_BITS stop bits (1). Each bit lasts
// CLKS_PER_BIT clock cycles. The line idles high.
//
// Build option:
//   UART_TX_PARITY_EN  When defined, the PARITY state and the parity bit are
//                      built. The parity bit is XOR(data) ^ PARITY_ODD.
//                      When undefined, no parity logic exists and PARITY_ODD
//                      is ignored.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   i_Clock      single clock
//   i_Reset      synchronous, active-high reset
//   i_Tx_DV      data word valid; accepted only while o_Tx_Ready is high
//   i_Tx_Byte    data word, DATA_BITS wide
//   o_Tx_Ready   holding register empty, a word can be accepted
//   o_Tx_Active  a frame is being shifted out
//   o_Tx_Serial  serial line output
//   o_Tx_Done    one-cycle pulse on the last cycle of every stop period
//
// All outputs are registered: they are computed from the current FSM state
// and registered, so the serial line trails the state register by one cycle.
// This places the first start-bit cycle two edges after the accepting edge.
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic            PAR_INIT  = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 ready_q, ready_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic accept;
  logic load;
  logic bit_end;

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    load      = 1'b0;
    serial_d  = 1'b1;
    active_d  = 1'b0;
    done_d    = 1'b0;
    bit_end   = (clk_cnt_q == CNT_LAST);

    // The bit-time counter free-runs in every state except IDLE and wraps
    // at the end of each bit; IDLE keeps it parked at zero.
    if (state_q != IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d   = START;
          load      = 1'b1;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        serial_d = shift_q[0];
        active_d = 1'b1;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_d = parity_q;
        active_d = 1'b1;
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
`endif

      STOP: begin
        serial_d = 1'b1;
        active_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            // A word waiting in the holding register starts the next frame
            // straight away, so back-to-back frames have no idle gap.
            if (hold_full_q) begin
              state_d = START;
              load    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      shift_d = hold_q;
    end
  end

  // -------------------------------------------------------------------------
  // Holding register. A word accepted on the same edge as a transfer wins the
  // holding slot while the previous word moves into the shift register.
  // -------------------------------------------------------------------------
  always_comb begin
    accept      = i_Tx_DV & ready_q;
    hold_d      = accept ? i_Tx_Byte : hold_q;
    hold_full_d = accept | (hold_full_q & ~load);
    // Ready is registered from the next holding state so it always equals
    // NOT(holding full) and never lets a second word overwrite the first.
    ready_d     = ~hold_full_d;
  end

`ifdef UART_TX_PARITY_EN
  // Parity is latched together with the word entering the shift register.
  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = (^hold_q) ^ PAR_INIT;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      serial_q    <= 1'b1;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      serial_q    <= serial_d;
      active_q    <= active_d;
      done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg -- scoreboard bench for uart_tx_cfg
//
// Two instances share clock and reset:
//   ch0: CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, PARITY_ODD=0
//   ch1: CLKS_PER_BIT=4, DATA_BITS=5, STOP_BITS=2, PARITY_ODD=1
// Every accepted word pushes its expected frame (bit pattern and the clock
// edge its start bit must appear on) into a queue. A monitor on the falling
// edge detects each start bit, pops the expected frame and compares the line,
// o_Tx_Active and o_Tx_Done on every cycle of the frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB0 = 11;
  localparam int NB1 = 9;
`else
  localparam int NB0 = 10;
  localparam int NB1 = 8;
`endif
  localparam int F0 = NB0 * CPB;
  localparam int F1 = NB1 * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dv0, dv1;
  logic [7:0] byte0;
  logic [4:0] byte1;
  logic       rdy0, act0, ser0, dn0;
  logic       rdy1, act1, ser1, dn1;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv0), .i_Tx_Byte(byte0),
    .o_Tx_Ready(rdy0), .o_Tx_Active(act0), .o_Tx_Serial(ser0), .o_Tx_Done(dn0)
  );

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv1), .i_Tx_Byte(byte1),
    .o_Tx_Ready(rdy1), .o_Tx_Active(act1), .o_Tx_Serial(ser1), .o_Tx_Done(dn1)
  );

  typedef struct {
    int          ch;
    int          nbits;
    logic [15:0] bits;
    int          start_edge;
    logic [8:0]  data;
  } frame_t;

  frame_t sb_q[$];
  int     total = 0;
  int     bad   = 0;
  int     edge_cnt = 0;
  int     last_start;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (edge %0d)", nm, got, want, edge_cnt);
    end
  endtask

  // Expected frame: start 0, data LSB first, optional parity, stop 1s.
  function automatic frame_t mk_frame(input int ch, input logic [8:0] d, input int start_edge);
    frame_t f;
    int db;
    int sb;
    db = (ch == 0) ? 8 : 5;
    sb = (ch == 0) ? 1 : 2;
    f.ch = ch;
    f.data = d;
    f.start_edge = start_edge;
    f.bits = '0;
    f.nbits = 1;
    for (int i = 0; i < db; i++) begin
      f.bits[f.nbits] = d[i];
      f.nbits++;
    end
`ifdef UART_TX_PARITY_EN
    begin
      logic p;
      p = (ch == 1);
      for (int i = 0; i < db; i++) p = p ^ d[i];
      f.bits[f.nbits] = p;
      f.nbits++;
    end
`endif
    for (int i = 0; i < sb; i++) begin
      f.bits[f.nbits] = 1'b1;
      f.nbits++;
    end
    return f;
  endfunction

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(posedge clk);
    #1;
  endtask

  // Present a word for one edge. fixed_start < 0 means the transmitter is
  // idle and the start bit is due two edges after acceptance.
  task automatic send(input int ch, input logic [8:0] d, input int fixed_start, input bit push);
    int e;
    frame_t f;
    @(posedge clk); #1;
    if (ch == 0) begin
      chk("ready_before_accept_ch0", {31'b0, rdy0}, 32'd1);
      dv0 = 1'b1; byte0 = d[7:0];
    end else begin
      chk("ready_before_accept_ch1", {31'b0, rdy1}, 32'd1);
      dv1 = 1'b1; byte1 = d[4:0];
    end
    @(posedge clk); #1;
    e = edge_cnt;
    dv0 = 1'b0; dv1 = 1'b0;
    if (ch == 0) chk("ready_after_accept_ch0", {31'b0, rdy0}, 32'd0);
    else         chk("ready_after_accept_ch1", {31'b0, rdy1}, 32'd0);
    f = mk_frame(ch, d, (fixed_start < 0) ? e + 2 : fixed_start);
    if (push) sb_q.push_back(f);
    last_start = f.start_edge;
  endtask

  // Present a word while the holding register is full; it must be dropped.
  task automatic drop0(input logic [7:0] d);
    @(posedge clk); #1;
    chk("ready_busy_ch0", {31'b0, rdy0}, 32'd0);
    dv0 = 1'b1; byte0 = d;
    @(posedge clk); #1;
    dv0 = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  frame_t cur [2];
  int     pos [2];
  bit     in_frame [2] = '{1'b0, 1'b0};
  logic   prev_ser [2] = '{1'b1, 1'b1};
  logic [1:0] ser_w, act_w, dn_w;
  assign ser_w = {ser1, ser0};
  assign act_w = {act1, act0};
  assign dn_w  = {dn1, dn0};

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!in_frame[c]) begin
        if (ser_w[c] === 1'b0 && prev_ser[c] === 1'b1) begin
          if (sb_q.size() == 0 || sb_q[0].ch != c) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame ch%0d got=start want=idle (edge %0d)", c, edge_cnt);
          end else begin
            cur[c] = sb_q.pop_front();
            in_frame[c] = 1'b1;
            pos[c] = 0;
            chk($sformatf("start_edge_ch%0d_d%0h", c, cur[c].data), edge_cnt, cur[c].start_edge);
          end
        end else if (ser_w[c] === 1'b1) begin
          chk($sformatf("idle_ch%0d", c), {30'b0, act_w[c], dn_w[c]}, 32'd0);
        end
      end
      if (in_frame[c]) begin
        chk($sformatf("frame_ch%0d_d%0h_pos%0d", c, cur[c].data, pos[c]),
            {29'b0, act_w[c], ser_w[c], dn_w[c]},
            {29'b0, 1'b1, cur[c].bits[pos[c] / CPB], (pos[c] == cur[c].nbits * CPB - 1)});
        pos[c]++;
        if (pos[c] == cur[c].nbits * CPB) in_frame[c] = 1'b0;
      end
      prev_ser[c] = ser_w[c];
    end
    // The reset edge follows this sample: any frame in flight is aborted.
    if (rst === 1'b1) begin
      in_frame[0] = 1'b0;
      in_frame[1] = 1'b0;
      sb_q.delete();
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int  s1, s2, s3, s4, sr;
  bit  seen_active;

  initial begin
    rst = 1'b1; dv0 = 1'b0; dv1 = 1'b0; byte0 = '0; byte1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ch0", {28'b0, rdy0, act0, ser0, dn0}, 32'b1010);
    chk("reset_ch1", {28'b0, rdy1, act1, ser1, dn1}, 32'b1010);
    rst = 1'b0;

    // Single frame 0xA5 from idle.
    send(0, 9'h0A5, -1, 1'b1);
    wait_edge(last_start + F0 + 3);

    // 0x11 then 0x22 accepted mid-frame, 0x33 dropped, 0x00 and 0xFF chained.
    send(0, 9'h011, -1, 1'b1);
    s1 = last_start;
    wait_edge(s1 + 10);
    s2 = s1 + F0;
    send(0, 9'h022, s2, 1'b1);
    drop0(8'h33);
    wait_edge(s2 + 2);
    s3 = s2 + F0;
    send(0, 9'h000, s3, 1'b1);
    wait_edge(s3 + 5);
    s4 = s3 + F0;
    send(0, 9'h0FF, s4, 1'b1);
    wait_edge(s4 + F0 + 3);

    // Five data bits, two stop bits.
    send(1, 9'h01F, -1, 1'b1);
    wait_edge(last_start + F1 + 3);
    send(1, 9'h00A, -1, 1'b1);
    wait_edge(last_start + F1 + 3);

    // Single-bit boundary pattern on ch0.
    send(0, 9'h080, -1, 1'b1);
    wait_edge(last_start + F0 + 3);

    // Reset at frame cycle 10 with a word held.
    send(0, 9'h03C, -1, 1'b1);
    sr = last_start;
    wait_edge(sr + 3);
    send(0, 9'h0C3, -1, 1'b0);
    wait_edge(sr + 9);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_ch0", {29'b0, ser0, act0, rdy0}, 32'b101);
    chk("after_reset_done_ch0", {31'b0, dn0}, 32'd0);
    dv0 = 1'b1; byte0 = 8'h77;
    @(posedge clk); #1;
    dv0 = 1'b0;
    rst = 1'b0;
    chk("dv_ignored_in_reset_ch0", {31'b0, rdy0}, 32'd1);
    seen_active = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (act0 !== 1'b0) seen_active = 1'b1;
    end
    chk("no_frame_after_reset_ch0", {31'b0, seen_active}, 32'd0);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
